gemm_cmd_bridge: RTL and testbench

Memory-mapped command bridge between the pipeline's memory/writeback stage and the GEMM accelerator. It decodes data-memory accesses that fall in the accelerator address window and collects operand addresses and dimensions into shadow registers. A write to CTRL.start pushes a descriptor into a command FIFO. Descriptors go to the accelerator over a valid/ready handshake, and completion is reported back through a readable STATUS register.

---
 rtl/gemm_cmd_bridge_if.sv | 27 ++
 rtl/gemm_cmd_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_gemm_cmd_bridge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_cmd_bridge_if.sv
// Bus bundle for gemm_cmd_bridge: the memory-stage access port and the
// accelerator descriptor/completion handshake.
// slave  : the bridge's view (decodes accesses, sources descriptors)
// master : the surrounding pipeline/accelerator view
interface gemm_cmd_bridge_if;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         mem_write;
    logic         mem_read;
    logic         hit_o;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [119:0] cmd_data;
    logic         done_i;

    modport slave (
        input  addr, wdata, mem_write, mem_read, cmd_ready, done_i,
        output hit_o, rdata_o, stall_o, cmd_valid, cmd_data
    );

    modport master (
        output addr, wdata, mem_write, mem_read, cmd_ready, done_i,
        input  hit_o, rdata_o, stall_o, cmd_valid, cmd_data
    );
endinterface

// File: rtl/gemm_cmd_bridge.sv
// gemm_cmd_bridge: memory-mapped command bridge to the GEMM accelerator.
// Shadow registers collect operands, a CTRL.start write queues a descriptor
// in a circular FIFO, descriptors leave over valid/ready, and completions are
// counted into STATUS.
// Optional feature: define GEMM_BRIDGE_IRQ_EN to add the CTRL.ie bit and the
// registered irq_o output.
module gemm_cmd_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          DEPTH     = 4
) (
    input  logic clk,
    input  logic reset,
    gemm_cmd_bridge_if.slave bus
`ifdef GEMM_BRIDGE_IRQ_EN
    ,
    output logic irq_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OFF_SRC_A  = 3'd0;
    localparam logic [2:0] OFF_SRC_B  = 3'd1;
    localparam logic [2:0] OFF_DST    = 3'd2;
    localparam logic [2:0] OFF_DIM    = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clean edges later
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    // Two-flop release synchroniser for the internal reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Address decode and handshake qualifiers
    // ------------------------------------------------------------------
    logic         hit;
    logic [2:0]   off;
    logic         wr;
    logic         ctrl_wr;
    logic         start_req;
    logic         ctrl_take;
    logic         push;
    logic         pop;
    logic         stall;

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  occ;
    logic         empty;
    logic         full;
    logic [4:0]   fifo_cnt;

    logic [31:0]  src_a;
    logic [31:0]  src_b;
    logic [31:0]  dst;
    logic [23:0]  dim;
    logic [4:0]   outstanding;
    logic [7:0]   done_cnt;
    logic [7:0]   done_next;
    logic         ie;
    logic         ie_next;
    logic [31:0]  status;
    logic [31:0]  rdata;

    assign hit       = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off       = bus.addr[4:2];
    assign wr        = bus.mem_write && hit;
    assign ctrl_wr   = wr && (off == OFF_CTRL);
    assign start_req = ctrl_wr && bus.wdata[0];

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign occ       = wptr - rptr;
    assign fifo_cnt  = 5'(occ);

    // A pop frees a slot in the same cycle, so a start into a full FIFO is
    // only held off when nothing leaves.
    assign pop       = !empty && bus.cmd_ready;
    assign stall     = start_req && full && !pop;
    assign push      = start_req && !stall;
    // The whole CTRL store is frozen while stalled; it is replayed later.
    assign ctrl_take = ctrl_wr && !stall;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [119:0] fifo_mem [DEPTH];

    // Descriptor storage, written on push
    // NOTE: the storage array has no reset; cmd_data is masked while empty so
    // stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr[AW-1:0]] <= {dim, dst, src_b, src_a};
    end

    // Read/write pointers with wrap bit
    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow operand registers
    // ------------------------------------------------------------------
    // Operand capture; values persist across pushes for back-to-back starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_a <= '0;
            src_b <= '0;
            dst   <= '0;
            dim   <= '0;
        end else if (wr) begin
            case (off)
                OFF_SRC_A: src_a <= bus.wdata;
                OFF_SRC_B: src_b <= bus.wdata;
                OFF_DST:   dst   <= bus.wdata;
                OFF_DIM:   dim   <= bus.wdata[23:0];
                default:   ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completion tracking
    // ------------------------------------------------------------------
    // Outstanding commands: +1 on pop, -1 on done, unchanged when both fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (pop && !bus.done_i) begin
            if (outstanding != 5'h1F) outstanding <= outstanding + 5'd1;
        end else if (bus.done_i && !pop && outstanding != '0) begin
            outstanding <= outstanding - 5'd1;
        end
    end

    // Next done count: clr wins but a coincident completion still counts
    // NOTE: every combinational output gets a default first so no latch forms.
    always_comb begin
        done_next = done_cnt;
        if (ctrl_take && bus.wdata[1]) begin
            done_next = bus.done_i ? 8'd1 : 8'd0;
        end else if (bus.done_i && done_cnt != 8'hFF) begin
            done_next = done_cnt + 8'd1;
        end
    end

    // Saturating completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_cnt <= '0;
        else        done_cnt <= done_next;
    end

`ifdef GEMM_BRIDGE_IRQ_EN
    assign ie_next = ctrl_take ? bus.wdata[2] : ie;

    // Interrupt enable and registered interrupt, both from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie    <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            ie    <= ie_next;
            irq_o <= ie_next && (done_next != 8'd0);
        end
    end
`else
    assign ie_next = 1'b0;
    assign ie      = ie_next;
`endif

    // ------------------------------------------------------------------
    // Read path and outputs
    // ------------------------------------------------------------------
    assign status = {6'b0, (fifo_cnt != 5'd0) || (outstanding != 5'd0), full,
                     done_cnt, 3'b0, outstanding, 3'b0, fifo_cnt};

    // Combinational register read mux; unmapped offsets read zero
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_SRC_A:  rdata = src_a;
                OFF_SRC_B:  rdata = src_b;
                OFF_DST:    rdata = dst;
                OFF_DIM:    rdata = {8'b0, dim};
                OFF_CTRL:   rdata = {29'b0, ie, 2'b0};
                OFF_STATUS: rdata = status;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.hit_o     = hit;
    assign bus.rdata_o   = rdata;
    assign bus.stall_o   = stall;
    assign bus.cmd_valid = !empty;
    assign bus.cmd_data  = empty ? '0 : fifo_mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_gemm_cmd_bridge.sv
// Self-checking bench for gemm_cmd_bridge. A queue-based reference model
// tracks the FIFO contents, counters and shadow registers at transaction level.
module tb_gemm_cmd_bridge;

    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gemm_cmd_bridge_if bus ();

`ifdef GEMM_BRIDGE_IRQ_EN
    logic irq;
`endif

    gemm_cmd_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GEMM_BRIDGE_IRQ_EN
        ,
        .irq_o (irq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [119:0] q[$];
    logic [31:0]  m_src_a, m_src_b, m_dst;
    logic [23:0]  m_dim;
    logic         m_ie;
    int           m_out, m_done;

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic m_start();
        return bus.mem_write && m_hit(bus.addr) && bus.addr[4:2] == 3'd4 && bus.wdata[0];
    endfunction

    function automatic logic m_stall();
        return m_start() && q.size() == DEPTH && !(q.size() != 0 && bus.cmd_ready);
    endfunction

    function automatic logic [31:0] m_status();
        logic [7:0] d;
        logic [4:0] o;
        logic [4:0] c;
        d = 8'(m_done);
        o = 5'(m_out);
        c = 5'(q.size());
        return {6'b0, (q.size() != 0 || m_out != 0), q.size() == DEPTH, d, 3'b0, o, 3'b0, c};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[4:2])
            3'd0: return m_src_a;
            3'd1: return m_src_b;
            3'd2: return m_dst;
            3'd3: return {8'b0, m_dim};
            3'd4: return {29'b0, m_ie, 2'b0};
            3'd5: return m_status();
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [119:0] m_head();
        return (q.size() != 0) ? q[0] : 120'h0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_src_a = 0; m_src_b = 0; m_dst = 0; m_dim = 0; m_ie = 0;
        m_out = 0; m_done = 0;
    endtask

    task automatic model_update();
        logic hit, pop, stall, push, take, done;
        hit   = m_hit(bus.addr);
        done  = bus.done_i;
        pop   = q.size() != 0 && bus.cmd_ready;
        stall = m_stall();
        push  = m_start() && !stall;
        take  = bus.mem_write && hit && bus.addr[4:2] == 3'd4 && !stall;
        if (pop) q.delete(0);
        if (push) q.push_back({m_dim, m_dst, m_src_b, m_src_a});
        if (pop && !done) m_out = (m_out < 31) ? m_out + 1 : 31;
        else if (done && !pop && m_out > 0) m_out = m_out - 1;
        if (take && bus.wdata[1]) m_done = done ? 1 : 0;
        else if (done && m_done < 255) m_done = m_done + 1;
`ifdef GEMM_BRIDGE_IRQ_EN
        if (take) m_ie = bus.wdata[2];
`endif
        if (bus.mem_write && hit) begin
            case (bus.addr[4:2])
                3'd0: m_src_a = bus.wdata;
                3'd1: m_src_b = bus.wdata;
                3'd2: m_dst   = bus.wdata;
                3'd3: m_dim   = bus.wdata[23:0];
                default: ;
            endcase
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.addr = 0; bus.wdata = 0; bus.mem_write = 0; bus.mem_read = 0;
        bus.cmd_ready = 0; bus.done_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
    endtask

    task automatic bus_write(input logic [4:0] o, input logic [31:0] d);
        bus.addr = BASE + 32'(o); bus.wdata = d; bus.mem_write = 1'b1;
        step();
        bus.mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] o, output logic [31:0] d);
        bus.addr = BASE + 32'(o); bus.mem_read = 1'b1;
        #1 d = bus.rdata_o;
        bus.mem_read = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.cmd_valid); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.cmd_data !== 120'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.cmd_data); end
`ifdef GEMM_BRIDGE_IRQ_EN
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
        for (int i = 0; i < 8; i++) begin
            bus_read(5'(i * 4), rd);
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", i, rd); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        do_reset();
        bus_write(5'h00, 32'h100);
        bus_write(5'h04, 32'h200);
        bus_write(5'h08, 32'h300);
        bus_write(5'h0C, 32'hFF04_0404);
        bus.cmd_ready = 1'b1;
        bus.addr = BASE + 32'h10; bus.wdata = 32'h1; bus.mem_write = 1'b1;
        #1;
        checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL basic_pre_valid got=%b exp=0", bus.cmd_valid); end
        step();
        bus.mem_write = 1'b0;
        #1;
        checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.cmd_valid); end
        checks++; if (bus.cmd_data !== {24'h040404, 32'h300, 32'h200, 32'h100})
            begin failures++; $display("FAIL basic_data got=%h exp=%h", bus.cmd_data, {24'h040404, 32'h300, 32'h200, 32'h100}); end
        step();
        bus.cmd_ready = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0200_0100) begin failures++; $display("FAIL basic_status got=%h exp=02000100", rd); end
        bus_read(5'h0C, rd);
        checks++; if (rd !== 32'h0004_0404) begin failures++; $display("FAIL basic_dim got=%h exp=00040404", rd); end
        bus_read(5'h00, rd);
        checks++; if (rd !== 32'h100) begin failures++; $display("FAIL basic_src_a_kept got=%h exp=100", rd); end
    endtask

    task automatic test_full_stall();
        logic [31:0] rd;
        do_reset();
        bus_write(5'h00, $urandom);
        bus_write(5'h08, $urandom);
        for (int i = 0; i < 4; i++) bus_write(5'h10, 32'h1);
        bus.addr = BASE + 32'h10; bus.wdata = 32'h1; bus.mem_write = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", bus.stall_o); end
        step();
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL full_stall_hold got=%b exp=1", bus.stall_o); end
        bus.mem_write = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0300_0004) begin failures++; $display("FAIL full_status got=%h exp=03000004", rd); end
        bus.addr = BASE + 32'h10; bus.wdata = 32'h1; bus.mem_write = 1'b1; bus.cmd_ready = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL full_pop_stall got=%b exp=0", bus.stall_o); end
        step();
        bus.mem_write = 1'b0; bus.cmd_ready = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0300_0104) begin failures++; $display("FAIL full_pop_status got=%h exp=03000104", rd); end
        checks++; if (bus.cmd_data !== m_head()) begin failures++; $display("FAIL full_head got=%h exp=%h", bus.cmd_data, m_head()); end
    endtask

    task automatic test_done();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(5'h10, 32'h1);
        bus.cmd_ready = 1'b1;
        repeat (3) step();
        bus.cmd_ready = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0200_0300) begin failures++; $display("FAIL done_out3 got=%h exp=02000300", rd); end
        bus.done_i = 1'b1;
        repeat (3) step();
        bus.done_i = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0003_0000) begin failures++; $display("FAIL done_cnt3 got=%h exp=00030000", rd); end
        bus.done_i = 1'b1;
        bus_write(5'h10, 32'h2);
        bus.done_i = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL done_clr got=%h exp=00010000", rd); end
    endtask

    task automatic test_saturate();
        logic [31:0] rd;
        logic [31:0] addrs [5];
        logic        exp_hit [5];
        addrs   = '{32'h0000_9000, 32'h0000_8020, 32'h0000_7FFC, 32'h0000_801C, 32'h0000_8003};
        exp_hit = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        bus.done_i = 1'b1;
        repeat (260) step();
        bus.done_i = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h00FF_0000) begin failures++; $display("FAIL sat_status got=%h exp=00ff0000", rd); end
        bus_write(5'h18, 32'hFFFF_FFFF);
        bus_read(5'h18, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL off18 got=%h exp=0", rd); end
        bus_read(5'h1C, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL off1c got=%h exp=0", rd); end
        bus_read(5'h00, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL off18_side got=%h exp=0", rd); end
        for (int i = 0; i < 5; i++) begin
            bus.addr = addrs[i];
            #1;
            checks++; if (bus.hit_o !== exp_hit[i]) begin failures++; $display("FAIL hit_%h got=%b exp=%b", addrs[i], bus.hit_o, exp_hit[i]); end
        end
        bus.addr = 32'h0000_9014; bus.mem_read = 1'b1;
        #1;
        checks++; if (bus.rdata_o !== 32'h0) begin failures++; $display("FAIL miss_rdata got=%h exp=0", bus.rdata_o); end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        do_reset();
        bus_write(5'h00, 32'hA5A5_0001);
        bus_write(5'h04, 32'hA5A5_0002);
        bus_write(5'h08, 32'hA5A5_0003);
        bus_write(5'h0C, 32'h0012_3456);
        for (int i = 0; i < 3; i++) bus_write(5'h10, 32'h1);
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL mid_pre_status got=%h exp=%h", rd, m_status()); end
        bus.addr = BASE + 32'h14; bus.mem_read = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.cmd_valid); end
        checks++; if (bus.rdata_o !== 32'h0) begin failures++; $display("FAIL mid_status got=%h exp=0", bus.rdata_o); end
        bus.mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            bus_read(5'(i * 4), rd);
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_shadow%0d got=%h exp=0", i, rd); end
        end
        bus.done_i = 1'b1;
        step();
        bus.done_i = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL mid_late_done got=%h exp=00010000", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        do_reset();
        bus_write(5'h00, $urandom);
        bus_write(5'h04, $urandom);
        bus_write(5'h0C, $urandom);
        bus.cmd_ready = 1'b1;
        bus.addr = BASE + 32'h10; bus.wdata = 32'h1; bus.mem_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bus.cmd_valid !== (q.size() != 0)) begin failures++; $display("FAIL b2b_valid%0d got=%b exp=%b", i, bus.cmd_valid, q.size() != 0); end
            checks++; if (bus.cmd_data !== m_head()) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, bus.cmd_data, m_head()); end
            checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall%0d got=%b exp=0", i, bus.stall_o); end
            step();
        end
        bus.mem_write = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== m_status()) begin failures++; $display("FAIL b2b_status got=%h exp=%h", rd, m_status()); end
        step();
        bus.cmd_ready = 1'b0;
        bus_read(5'h14, rd);
        checks++; if (rd !== 32'h0200_0600) begin failures++; $display("FAIL b2b_final got=%h exp=02000600", rd); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp_rd;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else if ($urandom_range(0, 3) == 0) a = BASE + 32'h10 + 32'($urandom_range(0, 3));
            else a = BASE + 32'($urandom_range(0, 31));
            bus.addr      = a;
            bus.wdata     = $urandom;
            bus.mem_write = ($urandom_range(0, 9) < 4);
            bus.mem_read  = $urandom_range(0, 1);
            bus.cmd_ready = $urandom_range(0, 1);
            bus.done_i    = ($urandom_range(0, 3) == 0);
            exp_rd = m_read(a);
            #1;
            checks++; if (bus.hit_o !== m_hit(a)) begin failures++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, bus.hit_o, m_hit(a)); end
            checks++; if (bus.stall_o !== m_stall()) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.stall_o, m_stall()); end
            checks++; if (bus.cmd_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.cmd_valid, q.size() != 0); end
            checks++; if (bus.cmd_data !== m_head()) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus.cmd_data, m_head()); end
            if (bus.mem_read) begin
                checks++; if (bus.rdata_o !== exp_rd) begin failures++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, a, bus.rdata_o, exp_rd); end
            end
`ifdef GEMM_BRIDGE_IRQ_EN
            checks++; if (irq !== (m_ie && m_done != 0)) begin failures++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, m_ie && m_done != 0); end
`endif
            step();
        end
        idle_inputs();
    endtask

`ifdef GEMM_BRIDGE_IRQ_EN
    task automatic test_irq();
        do_reset();
        bus_write(5'h10, 32'h4);
        bus.cmd_ready = 1'b1;
        bus_write(5'h10, 32'h5);
        step();
        bus.cmd_ready = 1'b0;
        bus.done_i = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_pre got=%b exp=0", irq); end
        step();
        bus.done_i = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        bus.addr = BASE + 32'h10; bus.wdata = 32'h6; bus.mem_write = 1'b1;
        #1;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq); end
        step();
        bus.mem_write = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
    endtask
`endif

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        test_reset();
        test_basic();
        test_full_stall();
        test_done();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
`ifdef GEMM_BRIDGE_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
